// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch-path definitions: FSM state encodings, instruction size, default width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_sequencer_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int INSTR_BYTES  = 4;

  // 3-bit state encodings for the fetch controller
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  // A fetch target must be word aligned; any set low bit is a misaligned redirect
  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: owns the PC, one imem request in flight, hands words to decode.
// Latency: 3 cycles per instruction with zero-wait memory (REQ, WAIT, HOLD); instr_valid one cycle after imem_rsp_valid.
// Backpressure: request held stable until imem_req_ready; instruction held until instr_ready; redirects squash wrong-path data.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            instr_valid,
  output logic [31:0]     instr_data,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  output logic            fetch_fault,
  output logic [XLEN-1:0] fault_pc
);

  state_t          state;
  logic [XLEN-1:0] pc;             // next address to fetch (latest redirect wins)
  logic            squash;         // in-flight response belongs to the wrong path
  logic            pend_fault;     // misaligned redirect waiting for the drain to finish
  logic [XLEN-1:0] pend_pc;        // the misaligned target to report once drained

  logic            req_valid_q;
  logic [XLEN-1:0] req_addr_q;     // address of the presented / in-flight request
  logic            instr_valid_q;
  logic [31:0]     instr_data_q;
  logic [XLEN-1:0] instr_pc_q;
  logic            fetch_fault_q;
  logic [XLEN-1:0] fault_pc_q;

  logic            redir_bad;
  logic            redir_good;
  logic [XLEN-1:0] pc_inc;
  logic            wait_fault;
  logic [XLEN-1:0] wait_fault_pc;
  logic [XLEN-1:0] wait_tgt;

  assign redir_bad  = redirect_valid & misaligned(redirect_pc[1:0]);
  assign redir_good = redirect_valid & ~redir_bad;
  assign pc_inc     = pc + XLEN'(INSTR_BYTES);

  // When a discarded response drains, a redirect arriving in the same cycle
  // supersedes whatever was pending from earlier redirects.
  assign wait_fault    = redirect_valid ? redir_bad   : pend_fault;
  assign wait_fault_pc = redirect_valid ? redirect_pc : pend_pc;
  assign wait_tgt      = redir_good     ? redirect_pc : pc;

  // Fetch FSM with inline PC, squash and pending-fault registers; all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      pc            <= RESET_PC;
      squash        <= 1'b0;
      pend_fault    <= 1'b0;
      pend_pc       <= '0;
      req_valid_q   <= 1'b0;
      req_addr_q    <= '0;
      instr_valid_q <= 1'b0;
      instr_data_q  <= '0;
      instr_pc_q    <= '0;
      fetch_fault_q <= 1'b0;
      fault_pc_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (redir_bad) begin
            state         <= ST_FAULT;
            fetch_fault_q <= 1'b1;
            fault_pc_q    <= redirect_pc;
          end else begin
            state       <= ST_REQ;
            req_valid_q <= 1'b1;
            req_addr_q  <= wait_tgt;
            pc          <= wait_tgt;
          end
        end

        ST_REQ: begin
          // The presented request is never withdrawn; a redirect only marks
          // its eventual response as wrong-path.
          if (redirect_valid) begin
            squash     <= 1'b1;
            pend_fault <= redir_bad;
            if (redir_bad) begin
              pend_pc <= redirect_pc;
            end else begin
              pc <= redirect_pc;
            end
          end
          if (imem_req_ready) begin
            req_valid_q <= 1'b0;
            state       <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (imem_rsp_valid) begin
            if (squash || redirect_valid) begin
              squash     <= 1'b0;
              pend_fault <= 1'b0;
              if (wait_fault) begin
                state         <= ST_FAULT;
                fetch_fault_q <= 1'b1;
                fault_pc_q    <= wait_fault_pc;
              end else begin
                state       <= ST_REQ;
                req_valid_q <= 1'b1;
                req_addr_q  <= wait_tgt;
                pc          <= wait_tgt;
              end
            end else if (imem_rsp_err) begin
              state         <= ST_FAULT;
              fetch_fault_q <= 1'b1;
              fault_pc_q    <= req_addr_q;
            end else begin
              state         <= ST_HOLD;
              instr_valid_q <= 1'b1;
              instr_data_q  <= imem_rsp_data;
              instr_pc_q    <= req_addr_q;
            end
          end else if (redirect_valid) begin
            squash     <= 1'b1;
            pend_fault <= redir_bad;
            if (redir_bad) begin
              pend_pc <= redirect_pc;
            end else begin
              pc <= redirect_pc;
            end
          end
        end

        ST_HOLD: begin
          // Redirect beats consumption: the held word is dropped either way
          if (redirect_valid) begin
            instr_valid_q <= 1'b0;
            if (redir_bad) begin
              state         <= ST_FAULT;
              fetch_fault_q <= 1'b1;
              fault_pc_q    <= redirect_pc;
            end else begin
              state       <= ST_REQ;
              req_valid_q <= 1'b1;
              req_addr_q  <= redirect_pc;
              pc          <= redirect_pc;
            end
          end else if (instr_ready) begin
            instr_valid_q <= 1'b0;
            state         <= ST_REQ;
            req_valid_q   <= 1'b1;
            req_addr_q    <= pc_inc;
            pc            <= pc_inc;
          end
        end

        ST_FAULT: begin
          if (redir_bad) begin
            fault_pc_q <= redirect_pc;
          end else if (redir_good) begin
            fetch_fault_q <= 1'b0;
            state         <= ST_REQ;
            req_valid_q   <= 1'b1;
            req_addr_q    <= redirect_pc;
            pc            <= redirect_pc;
          end
        end

        default: begin
          state         <= ST_IDLE;
          req_valid_q   <= 1'b0;
          instr_valid_q <= 1'b0;
          squash        <= 1'b0;
          pend_fault    <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign instr_valid    = instr_valid_q;
  assign instr_data     = instr_data_q;
  assign instr_pc       = instr_pc_q;
  assign fetch_fault    = fetch_fault_q;
  assign fault_pc       = fault_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: memory and decode models drive random timing and redirects.
// Expected program-order stream is queued at each redirect; a monitor pops and compares.
// Invariants (stable request, stable held instruction, single outstanding, no fetch in fault) checked every cycle.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_rsp_err = 1'b0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  fetch_sequencer #(.XLEN(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .fetch_fault(fetch_fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic is_fault; logic [31:0] pc; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;

  // bench control
  bit          run = 1'b0;
  bit          zero_wait = 1'b1;
  bit          rand_mode = 1'b0;
  bit          zw_check = 1'b0;
  bit          dir_req = 1'b0;
  logic [31:0] dir_pc = '0;
  int          stall_left = 0;

  // program image: a fixed word below 0x200, an address-derived word elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a < 32'h200) ? 32'h0000_0013 : {~a[15:0], a[15:0]};
  endfunction

  // access-fault map
  function automatic logic is_err(input logic [31:0] a);
    return (a == 32'h108) || (a[15:12] == 4'h5 && a[5:2] == 4'hB);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: from a target the program runs sequentially until the
  // first faulting address; a misaligned target faults immediately.
  task automatic load_expect(input logic [31:0] tgt);
    logic [31:0] a;
    a = tgt;
    exp_q.delete();
    if (tgt[1:0] != 2'b00) begin
      exp_q.push_back('{1'b1, tgt});
      return;
    end
    for (int i = 0; i < 64; i++) begin
      if (is_err(a)) begin
        exp_q.push_back('{1'b1, a});
        return;
      end
      exp_q.push_back('{1'b0, a});
      a = a + 32'd4;
    end
  endtask

  task automatic issue_redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    load_expect(tgt);
  endtask

  // ---------------- stimulus: memory, decode and redirect source ----------------
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  bit          seen_rv = 1'b0;
  logic [31:0] seen_addr = '0;
  bit          stim_prev_fault = 1'b0;
  bit          fault_new;
  logic [31:0] tgt;

  initial begin : stim
    forever begin
      @(posedge clk); #1;
      if (!run) begin
        redirect_valid = 1'b0; instr_ready = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        mem_busy = 1'b0; seen_rv = 1'b0;
      end else begin
        if (imem_rsp_valid) begin
          imem_rsp_valid = 1'b0;
          mem_busy = 1'b0;
        end
        if (seen_rv && imem_req_ready) begin
          mem_busy = 1'b1;
          mem_addr = seen_addr;
          mem_cnt  = zero_wait ? 0 : $urandom_range(0, 3);
        end
        if (mem_busy) begin
          if (mem_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr);
            imem_rsp_err   = is_err(mem_addr);
          end else begin
            mem_cnt--;
          end
        end
        if (!imem_rsp_valid) begin
          imem_rsp_data = $urandom;
          imem_rsp_err  = 1'($urandom_range(0, 1));
        end
        if (imem_req_valid && !mem_busy) begin
          if (stall_left > 0) begin
            imem_req_ready = 1'b0;
            stall_left--;
          end else begin
            imem_req_ready = zero_wait ? 1'b1 : 1'($urandom_range(0, 2) != 0);
          end
        end else begin
          imem_req_ready = 1'b0;
        end
        seen_rv   = imem_req_valid;
        seen_addr = imem_req_addr;
        instr_ready = zero_wait ? 1'b1 : 1'($urandom_range(0, 9) < 7);

        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
        fault_new       = fetch_fault && !stim_prev_fault;
        stim_prev_fault = fetch_fault;
        if (!fault_new) begin
          if (dir_req) begin
            issue_redirect(dir_pc);
            dir_req = 1'b0;
          end else if (rand_mode && ($urandom_range(0, fetch_fault ? 2 : 9) == 0)) begin
            tgt = {16'h0, 4'($urandom_range(2, 6)), 10'($urandom), 2'b00};
            if (!fetch_fault && $urandom_range(0, 5) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            issue_redirect(tgt);
          end
        end
      end
    end
  end

  // ---------------- monitor: scoreboard pops and protocol invariants ----------------
  bit          m_prev_fault = 1'b0;
  bit          m_prev_rv = 1'b0;
  bit          m_prev_rdy = 1'b0;
  logic [31:0] m_prev_addr = '0;
  bit          m_prev_iv = 1'b0;
  bit          m_prev_ir = 1'b0;
  bit          m_prev_redir = 1'b0;
  logic [31:0] m_prev_ipc = '0;
  logic [31:0] m_prev_idata = '0;
  bit          m_busy = 1'b0;
  int          m_cyc = 0;
  int          m_last_rise = -1;
  exp_t        e;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (run) begin
        if (fetch_fault && !m_prev_fault) begin
          chk("fault_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("fault_pc", fault_pc, e.pc);
            if (!e.is_fault) chk("fault_unexpected", 32'(fetch_fault), 32'd0);
          end
          zw_check = 1'b0;
        end
        if (fetch_fault) begin
          chk("no_req_in_fault", 32'(imem_req_valid), 32'd0);
          chk("no_instr_in_fault", 32'(instr_valid), 32'd0);
        end
        if (m_prev_rv && !m_prev_rdy) begin
          chk("req_held_valid", 32'(imem_req_valid), 32'd1);
          chk("req_held_addr", imem_req_addr, m_prev_addr);
        end
        if (m_prev_iv && !m_prev_ir && !m_prev_redir) begin
          chk("instr_held_valid", 32'(instr_valid), 32'd1);
          chk("instr_held_pc", instr_pc, m_prev_ipc);
          chk("instr_held_data", instr_data, m_prev_idata);
        end
        if (imem_req_valid && !m_prev_rv) begin
          chk("req_aligned", 32'(imem_req_addr[1:0]), 32'd0);
          if (zw_check && m_last_rise >= 0) chk("req_spacing", 32'(m_cyc - m_last_rise), 32'd3);
          m_last_rise = m_cyc;
        end
        if (imem_req_valid && m_busy) chk("single_outstanding", 32'(imem_req_valid), 32'd0);
        if (instr_valid && instr_ready && !redirect_valid) begin
          n_deliv++;
          chk("deliver_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("instr_pc", instr_pc, e.pc);
            chk("instr_data", instr_data, mem_word(e.pc));
            if (e.is_fault) chk("instr_instead_of_fault", 32'(instr_valid), 32'd0);
          end
        end
        if (imem_rsp_valid) m_busy = 1'b0;
        if (imem_req_valid && imem_req_ready) m_busy = 1'b1;
        m_prev_fault = fetch_fault;
        m_prev_rv    = imem_req_valid;
        m_prev_rdy   = imem_req_ready;
        m_prev_addr  = imem_req_addr;
        m_prev_iv    = instr_valid;
        m_prev_ir    = instr_ready;
        m_prev_redir = redirect_valid;
        m_prev_ipc   = instr_pc;
        m_prev_idata = instr_data;
      end
      m_cyc++;
    end
  end

  // ---------------- sequence ----------------
  int d0;

  initial begin : seq
    repeat (3) @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr_data", instr_data, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);

    // release just after an edge: one IDLE cycle, request in the second cycle
    load_expect(32'h100);
    zw_check = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run   = 1'b1;
    @(negedge clk);
    chk("idle_no_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h100);

    // zero-wait run from 0x100 ends with an access fault at 0x108
    for (int i = 0; i < 100 && !fetch_fault; i++) @(negedge clk);
    chk("err_fault_reached", 32'(fetch_fault), 32'd1);
    repeat (5) @(negedge clk);

    // leave the fault with a redirect; memory stalls the first request 4 cycles
    zero_wait  = 1'b0;
    stall_left = 4;
    d0 = n_deliv;
    dir_pc  = 32'h400;
    dir_req = 1'b1;
    for (int i = 0; i < 300 && (n_deliv - d0) < 2; i++) @(negedge clk);
    chk("redirect_0x400_progress", 32'((n_deliv - d0) >= 2), 32'd1);

    // misaligned redirect must fault without fetching its target
    dir_pc  = 32'h402;
    dir_req = 1'b1;
    for (int i = 0; i < 100 && !fetch_fault; i++) @(negedge clk);
    chk("misaligned_fault_reached", 32'(fetch_fault), 32'd1);
    repeat (5) @(negedge clk);

    // random timing and redirects
    d0 = n_deliv;
    rand_mode = 1'b1;
    repeat (4000) @(negedge clk);
    rand_mode = 1'b0;
    chk("random_phase_progress", 32'((n_deliv - d0) > 100), 32'd1);

    // asynchronous reset mid-operation
    run = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("arst_instr_valid", 32'(instr_valid), 32'd0);
    chk("arst_fetch_fault", 32'(fetch_fault), 32'd0);
    chk("arst_req_addr", imem_req_addr, 32'd0);
    chk("arst_fault_pc", fault_pc, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle fetch controller for the non-pipelined core. It owns the PC and issues one instruction-memory request at a time over a valid/ready handshake, tolerating variable memory latency. It presents each fetched instruction and its PC to decode with a valid/ready handshake. It also applies branch/trap redirects, squashing any wrong-path memory response.

## Interface
Parameters:
- XLEN, 32, PC and address width
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- redirect_valid  in  1  branch/jump/trap target is valid this cycle
- redirect_pc  in  XLEN  redirect target
- imem_req_valid  out  1  memory request presented
- imem_req_addr  out  XLEN  request address
- imem_req_ready  in  1  memory accepts request this cycle
- imem_rsp_valid  in  1  response data valid
- imem_rsp_data  in  32  fetched instruction
- imem_rsp_err  in  1  access fault, qualified by imem_rsp_valid
- instr_valid  out  1  instruction available to decode
- instr_data  out  32  instruction word
- instr_pc  out  XLEN  PC of instr_data
- instr_ready  in  1  decode consumes instruction
- fetch_fault  out  1  sticky fetch fault
- fault_pc  out  XLEN  address that faulted

## Operation
- States:
  - IDLE: reset state.
  - REQ: request presented.
  - WAIT: request accepted, response pending.
  - HOLD: instruction offered to decode.
  - FAULT: fault reported, fetch stopped.
- Registers:
  - pc: next address to fetch.
  - squash: the in-flight response is on the wrong path.
- IDLE: all outputs 0. Always moves to REQ on the next edge.
- REQ:
  - imem_req_valid=1 and imem_req_addr=pc.
  - Address stays stable until accepted. Redirect never retracts or alters a presented request.
  - On accept, go to WAIT.
- Redirect in REQ or WAIT:
  - pc<=redirect_pc.
  - If a request is accepted or in flight, set squash.
  - If no request has been accepted, the presented request still completes and its response is squashed.
- WAIT, on imem_rsp_valid:
  - If squash or redirect_valid in the same cycle: discard the response, clear squash, go to REQ at the latest pc.
  - Else if imem_rsp_err: go to FAULT with fault_pc=request address.
  - Else: latch instr_data and instr_pc=request address, go to HOLD.
- HOLD:
  - instr_valid=1; instr_data and instr_pc stay stable until consumed.
  - instr_ready without redirect: pc<=pc+4, go to REQ.
  - redirect_valid (whether or not instr_ready is high): the held instruction is dropped, pc<=redirect_pc, go to REQ. Redirect has priority.
- FAULT:
  - fetch_fault=1; no requests issued; instr_valid=0.
  - Exit only on redirect_valid: clear fault, pc<=redirect_pc, go to REQ.
  - fault_pc holds until the next fault.
- Misaligned redirect (redirect_pc[1:0]!=0), in any state:
  - go to FAULT with fault_pc=redirect_pc; no request is issued for it.
  - Any in-flight response is still drained and discarded via squash.
  - While draining, FAULT must not be entered before the response is received; hold in WAIT with a pending-fault flag.
- Multiple redirects before a response arrives: the last one wins.
- Arithmetic: pc+4 wraps modulo 2^XLEN; no overflow flag.
- Only one request is outstanding at any time.

## Timing
- Reset:
  - Every output is 0 and the state is IDLE while rst_n=0.
  - pc=RESET_PC.
  - squash=0 and fetch_fault=0.
- First request: imem_req_valid=1 in the second cycle after rst_n rises (IDLE for one cycle, then REQ).
- Zero-wait memory (imem_req_ready=1, response one cycle after accept) with instr_ready=1: REQ, WAIT, HOLD, then REQ. This gives 3 cycles per instruction.
- instr_valid rises the cycle after imem_rsp_valid.
- A redirect in HOLD deasserts instr_valid on the next cycle. A request to redirect_pc is presented that same next cycle.
- Reset mid-operation: state returns to IDLE asynchronously. Memory shares rst_n, so no stale response arrives after reset.

## Structure
- Shared core package/include holds:
  - state encodings (3-bit localparams IDLE/REQ/WAIT/HOLD/FAULT)
  - INSTR_BYTES=4
  - the XLEN default
- No sub-module. The PC, squash flag and pending-fault flag are inline registers in the FSM.

## Test plan
- Reset release, RESET_PC=0x100, zero-wait memory returning 0x00000013, instr_ready=1:
  - requests at 0x100, 0x104, 0x108, spaced 3 cycles apart.
  - instr_pc matches each address.
- imem_req_ready low for 4 cycles:
  - imem_req_addr=0x100 held stable all 4 cycles.
  - WAIT is entered only after accept.
- Redirect to 0x200 while in WAIT:
  - the response for 0x104 is discarded with no instr_valid.
  - the next request is at 0x200.
- HOLD with instr_ready=0 for 3 cycles, then redirect_valid and instr_ready together with target 0x300:
  - instr_valid drops.
  - the next request is at 0x300.
- imem_rsp_err on 0x108:
  - fetch_fault=1 and fault_pc=0x108; no further requests.
  - Redirect to 0x400 clears fault_fetch and a request at 0x400 follows.
- Redirect to 0x402:
  - FAULT with fault_pc=0x402.
  - no request to 0x402 is ever issued.
